// File: rtl/ocp_rr_arbiter_if.sv
// Bundle of the upstream (NUM_MST masters) and downstream (single slave) OCP signals around ocp_rr_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface ocp_rr_arbiter_if #(
  parameter int NUM_MST    = 2,
  parameter int TAGI_WIDTH = 5,
  parameter int BLEN_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [NUM_MST*3-1:0]          up_m_cmd;
  logic [NUM_MST*ADDR_WIDTH-1:0] up_m_addr;
  logic [NUM_MST*BLEN_WIDTH-1:0] up_m_burst_length;
  logic [NUM_MST*TAGI_WIDTH-1:0] up_m_tagid;
  logic [NUM_MST-1:0]            up_s_cmd_accept;
  logic [NUM_MST*DATA_WIDTH-1:0] up_m_data;
  logic [NUM_MST-1:0]            up_m_data_valid;
  logic [NUM_MST-1:0]            up_m_data_last;
  logic [NUM_MST-1:0]            up_s_data_accept;
  logic [NUM_MST*2-1:0]          up_s_resp;
  logic [DATA_WIDTH-1:0]         up_s_data;
  logic                          up_s_resp_last;
  logic [TAGI_WIDTH-1:0]         up_s_tagid;
  logic [NUM_MST-1:0]            up_m_resp_accept;

  logic [2:0]                    dn_m_cmd;
  logic [ADDR_WIDTH-1:0]         dn_m_addr;
  logic [BLEN_WIDTH-1:0]         dn_m_burst_length;
  logic [TAGI_WIDTH-1:0]         dn_m_tagid;
  logic                          dn_s_cmd_accept;
  logic [DATA_WIDTH-1:0]         dn_m_data;
  logic                          dn_m_data_valid;
  logic                          dn_m_data_last;
  logic                          dn_s_data_accept;
  logic [1:0]                    dn_s_resp;
  logic [DATA_WIDTH-1:0]         dn_s_data;
  logic                          dn_s_resp_last;
  logic [TAGI_WIDTH-1:0]         dn_s_tagid;
  logic                          dn_m_resp_accept;
  logic                          orphan_resp_err;

  modport slave (
    input  up_m_cmd, up_m_addr, up_m_burst_length, up_m_tagid,
           up_m_data, up_m_data_valid, up_m_data_last, up_m_resp_accept,
           dn_s_cmd_accept, dn_s_data_accept, dn_s_resp, dn_s_data,
           dn_s_resp_last, dn_s_tagid,
    output up_s_cmd_accept, up_s_data_accept, up_s_resp, up_s_data,
           up_s_resp_last, up_s_tagid,
           dn_m_cmd, dn_m_addr, dn_m_burst_length, dn_m_tagid,
           dn_m_data, dn_m_data_valid, dn_m_data_last, dn_m_resp_accept,
           orphan_resp_err
  );

  modport master (
    output up_m_cmd, up_m_addr, up_m_burst_length, up_m_tagid,
           up_m_data, up_m_data_valid, up_m_data_last, up_m_resp_accept,
           dn_s_cmd_accept, dn_s_data_accept, dn_s_resp, dn_s_data,
           dn_s_resp_last, dn_s_tagid,
    input  up_s_cmd_accept, up_s_data_accept, up_s_resp, up_s_data,
           up_s_resp_last, up_s_tagid,
           dn_m_cmd, dn_m_addr, dn_m_burst_length, dn_m_tagid,
           dn_m_data, dn_m_data_valid, dn_m_data_last, dn_m_resp_accept,
           orphan_resp_err
  );
endinterface

// File: rtl/ocp_rr_arbiter.sv
// Round-robin OCP command arbiter with write-data lock and tag-routed responses.
// Define OCP_ARB_STATS_EN to add the per-master saturating grant_cnt output.
module ocp_rr_arbiter #(
  parameter int NUM_MST    = 2,
  parameter int TAGI_WIDTH = 5,
  parameter int BLEN_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  ocp_rr_arbiter_if.slave bus
`ifdef OCP_ARB_STATS_EN
  ,
  output logic [NUM_MST*16-1:0] grant_cnt
`endif
);

  localparam int MW    = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int DEPTH = 1 << TAGI_WIDTH;

  typedef enum logic [1:0] {IDLE, CMD, WDATA} state_t;

  state_t                  state, state_nxt;
  logic [MW-1:0]           owner, rr_ptr, pick;
  logic                    pick_vld;
  logic [NUM_MST-1:0]      elig;
  logic [BLEN_WIDTH-1:0]   blen, beat_cnt;
  logic [BLEN_WIDTH:0]     beat_nxt;
  logic                    run;
  logic [DEPTH-1:0]        tbl_vld;
  logic [MW-1:0]           tbl_own [DEPTH];
  logic                    orphan;
  int                      own_i;
  int                      idx;

  logic [2:0]              own_cmd;
  logic [ADDR_WIDTH-1:0]   own_addr;
  logic [BLEN_WIDTH-1:0]   own_len;
  logic [TAGI_WIDTH-1:0]   own_tag;
  logic [DATA_WIDTH-1:0]   own_data;
  logic                    own_dvld, own_dlast;
  logic                    cmd_acc, beat_acc, beat_end;

  logic                    rvld;
  logic [MW-1:0]           rown;
  logic [NUM_MST*2-1:0]    resp_route;
  logic                    resp_acc, resp_clr, orphan_set;

  function automatic logic is_write(input logic [2:0] c);
    return (c == 3'd1) || (c == 3'd5) || (c == 3'd6) || (c == 3'd7);
  endfunction

  assign own_i     = int'(owner);
  assign own_cmd   = bus.up_m_cmd[own_i*3 +: 3];
  assign own_addr  = bus.up_m_addr[own_i*ADDR_WIDTH +: ADDR_WIDTH];
  assign own_len   = bus.up_m_burst_length[own_i*BLEN_WIDTH +: BLEN_WIDTH];
  assign own_tag   = bus.up_m_tagid[own_i*TAGI_WIDTH +: TAGI_WIDTH];
  assign own_data  = bus.up_m_data[own_i*DATA_WIDTH +: DATA_WIDTH];
  assign own_dvld  = bus.up_m_data_valid[own_i];
  assign own_dlast = bus.up_m_data_last[own_i];

  // Eligibility uses the table contents before this cycle's updates
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_MST; i++)
      elig[i] = (bus.up_m_cmd[i*3 +: 3] != 3'd0) &&
                !tbl_vld[bus.up_m_tagid[i*TAGI_WIDTH +: TAGI_WIDTH]];
  end

  // Walk downward so the lowest offset from rr_ptr is the last (winning) assignment
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = NUM_MST - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_MST) idx = idx - NUM_MST;
      if (elig[idx]) begin
        pick     = MW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign cmd_acc  = (state == CMD) && bus.dn_s_cmd_accept;
  assign beat_acc = (state == WDATA) && own_dvld && bus.dn_s_data_accept;
  assign beat_nxt = {1'b0, beat_cnt} + (BLEN_WIDTH+1)'(1);
  assign beat_end = beat_acc && (own_dlast || (beat_nxt == {1'b0, blen}));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = CMD;
      CMD:     if (bus.dn_s_cmd_accept) state_nxt = is_write(own_cmd) ? WDATA : IDLE;
      WDATA:   if (beat_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      owner    <= '0;
      rr_ptr   <= '0;
      blen     <= '0;
      beat_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (state == IDLE && pick_vld) owner <= pick;
      if (cmd_acc) begin
        rr_ptr   <= (owner == MW'(NUM_MST - 1)) ? '0 : owner + MW'(1);
        blen     <= own_len;
        beat_cnt <= '0;
      end
      if (beat_acc) beat_cnt <= beat_cnt + BLEN_WIDTH'(1);
    end
  end

  // A stale response clearing the tag a new command is claiming loses to the set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_vld <= '0;
    end else begin
      for (int t = 0; t < DEPTH; t++) begin
        if (cmd_acc && own_tag == TAGI_WIDTH'(t))                tbl_vld[t] <= 1'b1;
        else if (resp_clr && bus.dn_s_tagid == TAGI_WIDTH'(t))  tbl_vld[t] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_acc) tbl_own[own_tag] <= owner;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          orphan <= 1'b0;
    else if (orphan_set) orphan <= 1'b1;
  end

  assign rvld = tbl_vld[bus.dn_s_tagid];
  assign rown = tbl_own[bus.dn_s_tagid];

  // Response path is combinational; run keeps it quiet while reset is held
  always_comb begin
    resp_route = '0;
    resp_acc   = 1'b0;
    if (run) begin
      if (rvld) begin
        resp_route[int'(rown)*2 +: 2] = bus.dn_s_resp;
        resp_acc = bus.up_m_resp_accept[rown];
      end else if (bus.dn_s_resp != 2'd0) begin
        resp_acc = 1'b1;
      end
    end
  end

  assign resp_clr   = run && rvld && (bus.dn_s_resp != 2'd0) && bus.dn_s_resp_last && resp_acc;
  assign orphan_set = run && !rvld && (bus.dn_s_resp != 2'd0);

  assign bus.up_s_resp        = resp_route;
  assign bus.dn_m_resp_accept = resp_acc;
  assign bus.orphan_resp_err  = orphan;
  assign bus.up_s_data        = run ? bus.dn_s_data : '0;
  assign bus.up_s_resp_last   = run && bus.dn_s_resp_last;
  assign bus.up_s_tagid       = run ? bus.dn_s_tagid : '0;

  assign bus.dn_m_cmd          = (state == CMD) ? own_cmd  : 3'd0;
  assign bus.dn_m_addr         = (state == CMD) ? own_addr : '0;
  assign bus.dn_m_burst_length = (state == CMD) ? own_len  : '0;
  assign bus.dn_m_tagid        = (state == CMD) ? own_tag  : '0;
  assign bus.up_s_cmd_accept   = NUM_MST'(cmd_acc) << owner;

  assign bus.dn_m_data         = (state == WDATA) ? own_data : '0;
  assign bus.dn_m_data_valid   = (state == WDATA) && own_dvld;
  assign bus.dn_m_data_last    = (state == WDATA) && own_dlast;
  assign bus.up_s_data_accept  = NUM_MST'((state == WDATA) && bus.dn_s_data_accept) << owner;

`ifdef OCP_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_MST; i++)
        if (cmd_acc && owner == MW'(i) && grant_cnt[i*16 +: 16] != 16'hFFFF)
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ocp_rr_arbiter.sv
// Directed bench for ocp_rr_arbiter: response-routing vector table plus hand-written
// arbitration, write-burst, tag-blocking, orphan and mid-burst reset sequences.
module tb_ocp_rr_arbiter;

  localparam int NM = 2;
  localparam logic [2:0] WR = 3'd1, RD = 3'd2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   g [NM];

  ocp_rr_arbiter_if #(.NUM_MST(NM)) bus ();

`ifdef OCP_ARB_STATS_EN
  logic [NM*16-1:0] grant_cnt;
  ocp_rr_arbiter #(.NUM_MST(NM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .grant_cnt(grant_cnt));
`else
  ocp_rr_arbiter #(.NUM_MST(NM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  resp;
    logic [4:0]  tag;
    logic        last;
    logic [1:0]  racc;
    logic [31:0] data;
    logic [3:0]  exp_resp;
    logic        exp_racc;
  } rvec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic req(input int m, input logic [2:0] c, input logic [4:0] tag, input logic [3:0] len);
    bus.up_m_cmd[m*3 +: 3]          = c;
    bus.up_m_tagid[m*5 +: 5]        = tag;
    bus.up_m_burst_length[m*4 +: 4] = len;
    bus.up_m_addr[m*5 +: 5]         = 5'(tag + 1);
  endtask

  // Wait for a grant, check winner/tag, then retire the winner's request
  task automatic expect_grant(input int m, input logic [4:0] tag, input string name);
    logic          got;
    logic [NM-1:0] acc;
    got = 1'b0;
    acc = '0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (bus.up_s_cmd_accept != '0) begin
        got = 1'b1;
        acc = bus.up_s_cmd_accept;
        chk({name, "_who"}, 64'(acc), 64'(1) << m);
        chk({name, "_tag"}, 64'(bus.dn_m_tagid), 64'(tag));
      end
      @(posedge clk); #1;
      if (got)
        for (int i = 0; i < NM; i++)
          if (acc[i]) begin
            bus.up_m_cmd[i*3 +: 3] = 3'd0;
            g[i]++;
          end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout actual=no_grant required=grant_m%0d", name, m);
    end
  endtask

  task automatic clr_resp();
    bus.dn_s_resp = 2'd0; bus.dn_s_tagid = '0; bus.dn_s_resp_last = 1'b0;
    bus.up_m_resp_accept = '0; bus.dn_s_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rvec_t vt [10];
    int    pat [5];
    int    beat;

    vt[0] = '{2'd1, 5'd2, 1'b0, 2'b10, 32'h55, 4'b0100, 1'b1};
    vt[1] = '{2'd1, 5'd2, 1'b1, 2'b01, 32'h56, 4'b0100, 1'b0};
    vt[2] = '{2'd1, 5'd2, 1'b1, 2'b10, 32'h57, 4'b0100, 1'b1};
    vt[3] = '{2'd1, 5'd3, 1'b1, 2'b01, 32'h30, 4'b0001, 1'b1};
    vt[4] = '{2'd0, 5'd4, 1'b0, 2'b10, 32'h40, 4'b0000, 1'b1};
    vt[5] = '{2'd1, 5'd4, 1'b1, 2'b10, 32'h41, 4'b0100, 1'b1};
    vt[6] = '{2'd1, 5'd5, 1'b1, 2'b10, 32'h50, 4'b0001, 1'b0};
    vt[7] = '{2'd1, 5'd5, 1'b1, 2'b11, 32'h51, 4'b0001, 1'b1};
    vt[8] = '{2'd1, 5'd8, 1'b1, 2'b01, 32'h80, 4'b0001, 1'b1};
    vt[9] = '{2'd0, 5'd8, 1'b0, 2'b00, 32'h81, 4'b0000, 1'b0};
    pat = '{1, 0, 1, 1, 1};
    g[0] = 0; g[1] = 0;

    bus.up_m_cmd = '0; bus.up_m_addr = '0; bus.up_m_burst_length = '0; bus.up_m_tagid = '0;
    bus.up_m_data = '0; bus.up_m_data_valid = '0; bus.up_m_data_last = '0;
    bus.dn_s_cmd_accept = 1'b1; bus.dn_s_data_accept = 1'b1;
    clr_resp();

    // Reset state
    #12;
    chk("rst_dn_cmd", 64'(bus.dn_m_cmd), 0);
    chk("rst_cmd_acc", 64'(bus.up_s_cmd_accept), 0);
    chk("rst_data_acc", 64'(bus.up_s_data_accept), 0);
    chk("rst_dvld", 64'(bus.dn_m_data_valid), 0);
    chk("rst_resp_acc", 64'(bus.dn_m_resp_accept), 0);
    chk("rst_orphan", 64'(bus.orphan_resp_err), 0);
`ifdef OCP_ARB_STATS_EN
    chk("rst_gcnt", 64'(grant_cnt), 0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Simultaneous requests from rr_ptr=0, then rotation check
    req(0, RD, 5'd3, 4'd1); req(1, RD, 5'd4, 4'd1);
    expect_grant(0, 5'd3, "a_first");
    expect_grant(1, 5'd4, "a_second");
    req(0, RD, 5'd5, 4'd1); req(1, RD, 5'd2, 4'd1);
    expect_grant(0, 5'd5, "rr_m0");
    req(0, RD, 5'd8, 4'd1);
    expect_grant(1, 5'd2, "rr_m1");
    expect_grant(0, 5'd8, "rr_m0b");

    // Response routing table
    for (int i = 0; i < 10; i++) begin
      bus.dn_s_resp = vt[i].resp; bus.dn_s_tagid = vt[i].tag; bus.dn_s_resp_last = vt[i].last;
      bus.up_m_resp_accept = vt[i].racc; bus.dn_s_data = vt[i].data;
      @(negedge clk);
      chk($sformatf("v%0d_resp", i), 64'(bus.up_s_resp), 64'(vt[i].exp_resp));
      chk($sformatf("v%0d_racc", i), 64'(bus.dn_m_resp_accept), 64'(vt[i].exp_racc));
      chk($sformatf("v%0d_data", i), 64'(bus.up_s_data), 64'(vt[i].data));
      chk($sformatf("v%0d_tag", i), 64'(bus.up_s_tagid), 64'(vt[i].tag));
      chk($sformatf("v%0d_orph", i), 64'(bus.orphan_resp_err), 0);
      @(posedge clk); #1;
    end
    clr_resp();

    // Tag 7 held by M0 blocks M1 until the terminating response is accepted
    req(0, RD, 5'd7, 4'd1);
    expect_grant(0, 5'd7, "blk_m0");
    req(1, RD, 5'd7, 4'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("blk_wait_acc", 64'(bus.up_s_cmd_accept), 0);
      chk("blk_wait_cmd", 64'(bus.dn_m_cmd), 0);
      @(posedge clk); #1;
    end
    bus.dn_s_resp = 2'd1; bus.dn_s_tagid = 5'd7; bus.dn_s_resp_last = 1'b1; bus.up_m_resp_accept = 2'b01;
    @(negedge clk);
    chk("blk_resp", 64'(bus.up_s_resp), 64'h1);
    @(posedge clk); #1;
    clr_resp();
    @(negedge clk);
    chk("blk_free_cycle", 64'(bus.up_s_cmd_accept), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("blk_m1_acc", 64'(bus.up_s_cmd_accept), 64'h2);
    chk("blk_m1_tag", 64'(bus.dn_m_tagid), 64'd7);
    @(posedge clk); #1;
    bus.up_m_cmd[5:3] = 3'd0; g[1]++;

    // M1 write burst with a stalling downstream
    req(1, WR, 5'd10, 4'd4);
    expect_grant(1, 5'd10, "wr_grant");
    bus.up_m_data_valid = 2'b11; bus.up_m_data[31:0] = 32'hDEAD;
    beat = 0;
    for (int i = 0; i < 5; i++) begin
      bus.dn_s_data_accept = pat[i][0];
      bus.up_m_data[63:32] = 32'hA0 + 32'(beat);
      bus.up_m_data_last[1] = (beat == 3);
      @(negedge clk);
      chk("wr_m0_dacc", 64'(bus.up_s_data_accept[0]), 0);
      chk("wr_m1_dacc", 64'(bus.up_s_data_accept[1]), 64'(pat[i]));
      chk("wr_dvld", 64'(bus.dn_m_data_valid), 1);
      if (pat[i] != 0) chk("wr_beat", 64'(bus.dn_m_data), 64'(32'hA0 + 32'(beat)));
      @(posedge clk); #1;
      if (pat[i] != 0) beat++;
    end
    @(negedge clk);
    chk("wr_exit_dvld", 64'(bus.dn_m_data_valid), 0);
    @(posedge clk); #1;
    bus.up_m_data_valid = '0; bus.up_m_data_last = '0; bus.dn_s_data_accept = 1'b1;

    // Burst ends on length when data_last never comes
    req(0, WR, 5'd12, 4'd2);
    expect_grant(0, 5'd12, "cut_grant");
    bus.up_m_data_valid[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.up_m_data[31:0] = 32'hB0 + 32'(i);
      @(negedge clk);
      chk($sformatf("cut_vld%0d", i), 64'(bus.dn_m_data_valid), 64'(i < 2));
      @(posedge clk); #1;
    end
    bus.up_m_data_valid = '0;

    // Orphan response is dropped and latched
    bus.dn_s_resp = 2'd1; bus.dn_s_tagid = 5'd9; bus.dn_s_resp_last = 1'b1;
    @(negedge clk);
    chk("orph_racc", 64'(bus.dn_m_resp_accept), 1);
    chk("orph_resp", 64'(bus.up_s_resp), 0);
    @(posedge clk); #1;
    clr_resp();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("orph_sticky", 64'(bus.orphan_resp_err), 1);

    // Reset asserted during beat 2 of an M0 write burst
    @(posedge clk); #1;
    req(0, WR, 5'd11, 4'd4);
    expect_grant(0, 5'd11, "rst_grant");
    bus.up_m_data_valid[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.dn_s_resp = 2'd1; bus.dn_s_tagid = 5'd9; bus.dn_s_data = 32'h77;
    @(negedge clk);
    chk("pre_rst_dvld", 64'(bus.dn_m_data_valid), 1);
`ifdef OCP_ARB_STATS_EN
    chk("gcnt_m0", 64'(grant_cnt[15:0]), 64'(g[0]));
    chk("gcnt_m1", 64'(grant_cnt[31:16]), 64'(g[1]));
`endif
    #1 rst_n = 1'b0;
    #1;
    chk("arst_dvld", 64'(bus.dn_m_data_valid), 0);
    chk("arst_dacc", 64'(bus.up_s_data_accept), 0);
    chk("arst_dn_cmd", 64'(bus.dn_m_cmd), 0);
    chk("arst_orphan", 64'(bus.orphan_resp_err), 0);
    chk("arst_racc", 64'(bus.dn_m_resp_accept), 0);
    chk("arst_up_data", 64'(bus.up_s_data), 0);
`ifdef OCP_ARB_STATS_EN
    chk("arst_gcnt", 64'(grant_cnt), 0);
`endif
    bus.up_m_data_valid = '0;
    clr_resp();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    bus.dn_s_resp = 2'd1; bus.dn_s_tagid = 5'd10; bus.dn_s_resp_last = 1'b1; bus.up_m_resp_accept = 2'b00;
    @(negedge clk);
    chk("arst_tbl_racc", 64'(bus.dn_m_resp_accept), 1);
    chk("arst_tbl_resp", 64'(bus.up_s_resp), 0);
    @(posedge clk); #1;
    clr_resp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
